// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, instruction field
// positions, FSM states and the writes-a-register rule.
package alu_pkg;

    localparam logic [2:0] OP_NOOP0 = 3'b000;
    localparam logic [2:0] OP_NOOP1 = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_ADDI  = 3'b110;
    localparam logic [2:0] OP_SUBI  = 3'b111;

    localparam int INSTR_W = 32;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 29;
    localparam int RD_LSB  = 24;
    localparam int RS1_LSB = 19;
    localparam int RS2_LSB = 14;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // Both 000 and 001 are no-ops; every other op produces a register result.
    function automatic logic op_has_result(input logic [2:0] op);
        return (op != OP_NOOP0) && (op != OP_NOOP1);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// instr_field_decode: pure combinational split of a latched instruction word
// into op, register addresses, sign-extended immediate and the write flag.
module instr_field_decode
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 14
) (
    input  logic [INSTR_W-1:0]    instr,
    output logic [2:0]            op,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0]     imm_ext,
    output logic                  writes_reg
);

    assign op  = instr[OP_MSB:OP_LSB];
    assign rd  = instr[RD_LSB  +: REG_ADDR_W];
    assign rs1 = instr[RS1_LSB +: REG_ADDR_W];
    assign rs2 = instr[RS2_LSB +: REG_ADDR_W];

    assign imm_ext = {{(DATA_W - IMM_W){instr[IMM_LSB + IMM_W - 1]}}, instr[IMM_LSB +: IMM_W]};

    // Writes to r0 are dropped here so the sequencer can skip the WB state.
    assign writes_reg = op_has_result(op) && (rd != '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: IDLE/DECODE/EXEC/WB sequencer that issues one ALU op and one
// register write per instruction. Define ALU_ISSUE_RETIRE_COUNT_EN for retire_cnt.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [2:0]            alu_op,
    output logic [DATA_W-1:0]     imm,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  done
`ifdef ALU_ISSUE_RETIRE_COUNT_EN
    ,
    output logic [31:0]           retire_cnt
`endif
);

    state_t                state;
    logic [INSTR_W-1:0]    instr_q;

    logic [2:0]            dec_op;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic [DATA_W-1:0]     dec_imm;
    logic                  dec_writes;

    instr_field_decode #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .IMM_W      (IMM_W)
    ) u_decode (
        .instr      (instr_q),
        .op         (dec_op),
        .rd         (dec_rd),
        .rs1        (dec_rs1),
        .rs2        (dec_rs2),
        .imm_ext    (dec_imm),
        .writes_reg (dec_writes)
    );

    // All outputs are registered; rf_we and done default low so they pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            instr_q     <= '0;
            instr_ready <= 1'b1;
            rs1_addr    <= '0;
            rs2_addr    <= '0;
            rd_addr     <= '0;
            alu_op      <= OP_NOOP0;
            imm         <= '0;
            wb_data     <= '0;
            rf_we       <= 1'b0;
            done        <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    rs1_addr <= dec_rs1;
                    rs2_addr <= dec_rs2;
                    rd_addr  <= dec_rd;
                    imm      <= dec_imm;
                    alu_op   <= dec_op;
                    state    <= ST_EXEC;
                end
                ST_EXEC: begin
                    alu_op  <= OP_NOOP0;
                    wb_data <= alu_result;
                    done    <= 1'b1;
                    if (dec_writes) begin
                        rf_we <= 1'b1;
                        state <= ST_WB;
                    end else begin
                        instr_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    alu_op      <= OP_NOOP0;
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_RETIRE_COUNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= '0;
        end else if (done) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl with a cycle-phase reference model and an ALU/RF stub.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [2:0]  alu_op;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rd_addr;
    logic [31:0] wb_data;
    logic        done;
`ifdef ALU_ISSUE_RETIRE_COUNT_EN
    logic [31:0] retire_cnt;
`endif

    int errors;
    int checks;
    int exp_retired;

    logic [31:0] seed   [32];
    logic [31:0] rf_dut [32];
    logic [31:0] rf_ref [32];
    logic [31:0] seq_q  [$];

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .alu_op      (alu_op),
        .imm         (imm),
        .alu_result  (alu_result),
        .rf_we       (rf_we),
        .rd_addr     (rd_addr),
        .wb_data     (wb_data),
        .done        (done)
`ifdef ALU_ISSUE_RETIRE_COUNT_EN
        ,
        .retire_cnt  (retire_cnt)
`endif
    );

    // Environment register file: reloads the seed on reset, takes DUT writes.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_dut[i] <= seed[i];
        end else if (rf_we) begin
            rf_dut[rd_addr] <= wb_data;
        end
    end

    // Combinational ALU stub fed by the environment register file.
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    always_comb begin
        alu_a      = rf_dut[rs1_addr];
        alu_b      = rf_dut[rs2_addr];
        alu_result = 32'hA5A5_0000 ^ alu_a;
        case (alu_op)
            3'b010:  alu_result = alu_a + alu_b;
            3'b011:  alu_result = alu_a - alu_b;
            3'b100:  alu_result = alu_a << alu_b[4:0];
            3'b101:  alu_result = alu_a >> alu_b[4:0];
            3'b110:  alu_result = alu_a + imm;
            3'b111:  alu_result = alu_a - imm;
            default: alu_result = 32'hA5A5_0000 ^ alu_a;
        endcase
    end

    // Architectural result of an instruction against the reference register file.
    function automatic logic [31:0] ref_result(input logic [31:0] ins);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ix;
        a  = rf_ref[ins[23:19]];
        b  = rf_ref[ins[18:14]];
        ix = {{18{ins[13]}}, ins[13:0]};
        case (ins[31:29])
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b100:  return a << b[4:0];
            3'b101:  return a >> b[4:0];
            3'b110:  return a + ix;
            3'b111:  return a - ix;
            default: return 32'h0;
        endcase
    endfunction

    task automatic apply_reset();
        rst         = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) rf_ref[i] = seed[i];
        exp_retired = 0;
    endtask

    // Drives seq_q and checks every cycle against the per-phase expectations:
    // phase 1 DECODE, 2 EXEC, 3 write/done, 4 back in IDLE (write path only).
    task automatic run_seq(input bit hold);
        int          n;
        int          idx;
        int          k;
        int          hs;
        int          ph;
        int          budget;
        bit          busy;
        bit          gap_done;
        bit          idle_now;
        bit          exp_wr;
        logic [31:0] cur;
        logic [31:0] exp_data;
        logic [31:0] exp_imm;
        n        = seq_q.size();
        idx      = 0;
        k        = 0;
        hs       = 0;
        busy     = 1'b0;
        gap_done = 1'b1;
        exp_wr   = 1'b0;
        cur      = '0;
        exp_data = '0;
        exp_imm  = '0;
        budget   = 6 * n + 12;
        while ((idx < n || busy) && budget > 0) begin
            @(negedge clk);
            k++;
            budget--;
            idle_now = 1'b0;
            if (busy) begin
                ph = k - hs;
                if (ph == 1) begin
                    if (!hold) begin
                        instr_valid = 1'b0;
                        instr       = $urandom;
                    end
                    checks++;
                    if ({instr_ready, alu_op, rf_we, done} !== 6'b0) begin
                        errors++;
                        $display("FAIL decode_ctl instr=%h got rdy=%b op=%b we=%b done=%b want all 0",
                                 cur, instr_ready, alu_op, rf_we, done);
                    end
                end else if (ph == 2) begin
                    checks++;
                    if ({alu_op, rs1_addr, rs2_addr, imm} !== {cur[31:29], cur[23:19], cur[18:14], exp_imm}) begin
                        errors++;
                        $display("FAIL exec_fields instr=%h got op=%b rs1=%0d rs2=%0d imm=%h want op=%b rs1=%0d rs2=%0d imm=%h",
                                 cur, alu_op, rs1_addr, rs2_addr, imm, cur[31:29], cur[23:19], cur[18:14], exp_imm);
                    end
                    checks++;
                    if ({instr_ready, rf_we, done} !== 3'b000) begin
                        errors++;
                        $display("FAIL exec_ctl instr=%h got rdy=%b we=%b done=%b want 000",
                                 cur, instr_ready, rf_we, done);
                    end
                end else if (ph == 3) begin
                    checks++;
                    if ({alu_op, done, rf_we, instr_ready} !== {3'b000, 1'b1, exp_wr, !exp_wr}) begin
                        errors++;
                        $display("FAIL retire_ctl instr=%h got op=%b done=%b we=%b rdy=%b want op=000 done=1 we=%b rdy=%b",
                                 cur, alu_op, done, rf_we, instr_ready, exp_wr, !exp_wr);
                    end
                    if (exp_wr) begin
                        checks++;
                        if ({rd_addr, wb_data} !== {cur[28:24], exp_data}) begin
                            errors++;
                            $display("FAIL wb_data instr=%h got rd=%0d data=%h want rd=%0d data=%h",
                                     cur, rd_addr, wb_data, cur[28:24], exp_data);
                        end
                    end else begin
                        busy     = 1'b0;
                        idle_now = 1'b1;
                    end
                    exp_retired++;
                end else begin
                    checks++;
                    if ({instr_ready, rf_we, done} !== 3'b100) begin
                        errors++;
                        $display("FAIL post_wb instr=%h got rdy=%b we=%b done=%b want 100",
                                 cur, instr_ready, rf_we, done);
                    end
                    busy     = 1'b0;
                    idle_now = 1'b1;
                end
            end else begin
                checks++;
                if ({instr_ready, rf_we, done} !== 3'b100) begin
                    errors++;
                    $display("FAIL idle_ctl got rdy=%b we=%b done=%b want 100", instr_ready, rf_we, done);
                end
                idle_now = 1'b1;
            end
            if (idle_now) begin
                if (idx < n && (hold || gap_done)) begin
                    cur         = seq_q[idx];
                    idx++;
                    instr       = cur;
                    instr_valid = 1'b1;
                    hs          = k;
                    busy        = 1'b1;
                    gap_done    = 1'b0;
                    exp_imm     = {{18{cur[13]}}, cur[13:0]};
                    exp_wr      = (cur[31:29] >= 3'b010) && (cur[28:24] != 5'd0);
                    exp_data    = ref_result(cur);
                    if (exp_wr) rf_ref[cur[28:24]] = exp_data;
                end else begin
                    instr_valid = 1'b0;
                    gap_done    = 1'b1;
                end
            end
        end
        instr_valid = 1'b0;
        checks++;
        if (idx < n || busy) begin
            errors++;
            $display("FAIL seq_timeout issued=%0d of %0d busy=%b", idx, n, busy);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        @(negedge clk);
        checks++;
        if ({instr_ready, alu_op, imm, rs1_addr, rs2_addr, rd_addr, wb_data, rf_we, done} !==
            {1'b1, 3'b000, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b op=%b imm=%h rs1=%0d rs2=%0d rd=%0d wb=%h we=%b done=%b",
                     instr_ready, alu_op, imm, rs1_addr, rs2_addr, rd_addr, wb_data, rf_we, done);
        end
`ifdef ALU_ISSUE_RETIRE_COUNT_EN
        checks++;
        if (retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_retire got %h want 0", retire_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) rf_ref[i] = seed[i];
        exp_retired = 0;
        @(negedge clk);
        checks++;
        if ({instr_ready, rf_we, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release got rdy=%b we=%b done=%b want 100", instr_ready, rf_we, done);
        end
    endtask

    task automatic test_add();
        seq_q.delete();
        seq_q.push_back(32'h4308_8000);
        run_seq(1'b0);
    endtask

    task automatic test_addi_neg();
        seq_q.delete();
        seq_q.push_back(32'hC508_3FFF);
        run_seq(1'b0);
    endtask

    task automatic test_noop_rd0();
        seq_q.delete();
        seq_q.push_back(32'h0000_0000);
        seq_q.push_back(32'h4008_8000);
        seq_q.push_back(32'h2A5A_1234);
        run_seq(1'b0);
    endtask

    task automatic test_back_to_back();
        seq_q.delete();
        seq_q.push_back({3'b010, 5'd9,  5'd3, 5'd4, 14'd0});
        seq_q.push_back({3'b011, 5'd10, 5'd9, 5'd5, 14'd0});
        seq_q.push_back({3'b100, 5'd11, 5'd10, 5'd6, 14'd0});
        run_seq(1'b1);
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int b = 0; b < 2; b++) begin
            seq_q.delete();
            for (int i = 0; i < 12; i++) begin
                w[31:29] = 3'($urandom_range(0, 7));
                w[28:24] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                w[23:19] = 5'($urandom_range(0, 31));
                w[18:14] = 5'($urandom_range(0, 31));
                w[13:0]  = 14'($urandom_range(0, 16383));
                seq_q.push_back(w);
            end
            run_seq(b == 0);
        end
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle got rdy=%b want 1", instr_ready);
        end
        instr       = {3'b010, 5'd7, 5'd1, 5'd2, 14'd0};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_op !== 3'b010) begin
            errors++;
            $display("FAIL midrst_exec got op=%b want 010", alu_op);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({alu_op, rf_we, instr_ready, done, rd_addr, wb_data} !== {3'b000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0}) begin
            errors++;
            $display("FAIL midrst_async got op=%b we=%b rdy=%b done=%b rd=%0d wb=%h want 000 0 1 0 0 0",
                     alu_op, rf_we, instr_ready, done, rd_addr, wb_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) rf_ref[i] = seed[i];
        exp_retired = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rf_we, done, instr_ready} !== 3'b001) begin
                errors++;
                $display("FAIL midrst_nowrite cyc=%0d got we=%b done=%b rdy=%b want 001",
                         i, rf_we, done, instr_ready);
            end
        end
    endtask

`ifdef ALU_ISSUE_RETIRE_COUNT_EN
    task automatic test_retire();
        apply_reset();
        seq_q.delete();
        seq_q.push_back({3'b010, 5'd12, 5'd1, 5'd2, 14'd0});
        seq_q.push_back({3'b001, 5'd13, 5'd1, 5'd2, 14'd0});
        seq_q.push_back({3'b110, 5'd14, 5'd3, 5'd0, 14'h2001});
        seq_q.push_back({3'b011, 5'd0,  5'd4, 5'd5, 14'd0});
        seq_q.push_back({3'b101, 5'd15, 5'd6, 5'd7, 14'd0});
        run_seq(1'b1);
        @(negedge clk);
        checks++;
        if (retire_cnt !== 32'(exp_retired) || exp_retired != 5) begin
            errors++;
            $display("FAIL retire_count got %0d want 5 (model %0d)", retire_cnt, exp_retired);
        end
        force dut.retire_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retire_q;
        @(negedge clk);
        checks++;
        if (retire_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL retire_preload got %h want ffffffff", retire_cnt);
        end
        seq_q.delete();
        seq_q.push_back({3'b010, 5'd16, 5'd1, 5'd2, 14'd0});
        run_seq(1'b0);
        @(negedge clk);
        checks++;
        if (retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL retire_wrap got %h want 0", retire_cnt);
        end
    endtask
`endif

    initial begin
        errors      = 0;
        checks      = 0;
        exp_retired = 0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        for (int i = 0; i < 32; i++) seed[i] = $urandom;
        seed[1] = 32'd3;
        seed[2] = 32'd4;
        for (int i = 0; i < 32; i++) rf_ref[i] = seed[i];

        test_reset();
        test_add();
        test_addi_neg();
        test_noop_rd0();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
`ifdef ALU_ISSUE_RETIRE_COUNT_EN
        test_retire();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle instruction sequencer that accepts 32-bit instructions over a valid/ready handshake and decodes them.
- Drives the datapath ALU (alu_op, imm) and register-file read addresses.
- Captures the ALU result one cycle later and issues a single register-file write.
- Sits between the instruction source and the ALU/register-file datapath; it is the producer of every ALU operation code.

Parameters:
- DATA_W, 32, datapath / ALU operand width.
- REG_ADDR_W, 5, register-file address width.
- IMM_W, 14, immediate field width; 3 + 3*REG_ADDR_W + IMM_W must equal 32.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller can accept.
- instr  in  32  [31:29] op, [28:24] rd, [23:19] rs1, [18:14] rs2, [13:0] imm.
- rs1_addr  out  REG_ADDR_W  register-file read port A address.
- rs2_addr  out  REG_ADDR_W  register-file read port B address.
- alu_op  out  3  ALU operation code.
- imm  out  DATA_W  sign-extended immediate to ALU.
- alu_result  in  DATA_W  combinational ALU output.
- rf_we  out  1  register-file write enable.
- rd_addr  out  REG_ADDR_W  write address.
- wb_data  out  DATA_W  write data.
- done  out  1  one-cycle pulse per retired instruction.

Behaviour:
- Op encoding, fixed:
  - 000/001 NOOP
  - 010 ADD
  - 011 SUB
  - 100 SHIFTL
  - 101 SHIFTR
  - 110 ADDI
  - 111 SUBI
- FSM states: IDLE, DECODE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr; go to DECODE.
  - instr_ready is low in every other state; the source must hold instr while valid and not ready.
- DECODE:
  - Register rs1_addr, rs2_addr, rd_addr.
  - imm = sign-extended imm[13:0] (bit 13 replicated to DATA_W).
  - Go to EXEC.
- EXEC:
  - alu_op = latched op; 000 in all other states.
  - At the end of EXEC, wb_data <= alu_result.
  - Next state is WB, unless op is NOOP (000/001) or rd==0; those go to IDLE with done=1 and no write.
- WB:
  - rf_we=1 for exactly one cycle, with rd_addr/wb_data stable.
  - done=1; go to IDLE.
- Latency: handshake edge -> rf_we high is 3 cycles.
- Throughput: 1 instruction per 4 cycles (per 3 for suppressed writes).
- Reset values (also applied mid-operation):
  - State IDLE.
  - instr_ready=1.
  - alu_op=000, imm=0, rs1_addr=0, rs2_addr=0, rd_addr=0, wb_data=0.
  - rf_we=0, done=0.
- Reset asserted mid-operation: the in-flight instruction is discarded and no write is issued.
- rs1/rs2 addresses remain stable from DECODE through EXEC.
- Shift amounts and overflow are the ALU's concern; the controller passes the full result unmodified.

Optional Feature:
- Macro: ALU_ISSUE_RETIRE_COUNT_EN.
- When defined:
  - Adds output retire_cnt [31:0].
  - Increments on every done pulse, wrapping 0xFFFFFFFF -> 0.
  - Reset to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg contains:
  - The 3-bit op localparams (OP_NOOP0, OP_NOOP1, OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_ADDI, OP_SUBI).
  - Instruction field bit positions.
  - The FSM state enum.
- One natural sub-module, instr_field_decode: combinational field extraction, sign extension and the writes-register flag. It is instantiated once.

Test Plan:
- Reset check: assert rst mid-EXEC of an ADD -> same cycle alu_op=000, rf_we=0, instr_ready=1; no write occurs after release.
- ADD: instr=0x43088000 (rd3, rs1 1, rs2 2); ALU model returns 7 -> in EXEC alu_op=010, rs1_addr=1, rs2_addr=2; 3 cycles after handshake rf_we=1, rd_addr=3, wb_data=7, done=1.
- ADDI negative immediate: instr=0xC5083FFF -> imm=0xFFFFFFFF, alu_op=110, rd_addr=5.
- NOOP and rd==0: instr=0x00000000 and instr=0x40088000 -> done pulses, rf_we never asserted, instr_ready returns after 3 cycles.
- Back-to-back valid: hold instr_valid=1 with 3 different instructions -> instr_ready high only in IDLE, each accepted exactly once, writes in order 4 cycles apart.
- ALU_ISSUE_RETIRE_COUNT_EN defined: 5 instructions, including 1 NOOP -> retire_cnt=5; preload near wrap -> 0xFFFFFFFF+1 = 0.
